// File: rtl/mem_ctrl_pkg.sv
// mem_ctrl_pkg: shared encodings, widths and the IO window base for the memory controller
package mem_ctrl_pkg;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 32;
  localparam logic [ADDR_W-1:0] IO_BASE = 32'h0003_0000;
  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;
  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_e;
  function automatic logic [2:0] size_bytes(input logic [1:0] s);
    return s == SZ_BYTE ? 3'd1 : s == SZ_HALF ? 3'd2 : 3'd4;
  endfunction
endpackage

// File: rtl/mem_ctrl.sv
// mem_ctrl: arbitrates icache/LSB requests and serialises them into byte RAM/IO accesses
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter logic [ADDR_W-1:0] IO_BASE_ADDR = IO_BASE
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic [7:0]        mem_din,
  output logic [7:0]        mem_dout,
  output logic [ADDR_W-1:0] mem_a,
  output logic              mem_wr,
  input  logic              io_buffer_full,
  input  logic              valid_from_icache,
  input  logic [ADDR_W-1:0] addr_from_icache,
  output logic              valid_to_icache,
  output logic [DATA_W-1:0] data_to_icache,
  input  logic              valid_from_lsb,
  input  logic              wr_from_lsb,
  input  logic [1:0]        size_from_lsb,
  input  logic [ADDR_W-1:0] addr_from_lsb,
  input  logic [DATA_W-1:0] data_from_lsb,
  output logic              valid_to_lsb,
  output logic [DATA_W-1:0] data_to_lsb
);
  state_e            state_q;
  logic [2:0]        cnt_q, cnt_d, n_q;
  logic [ADDR_W-1:0] addr_q, a_q, a_d;
  logic [DATA_W-1:0] data_q, buf_q;
  logic [7:0]        dout_q, byte_d;
  logic              wr_q, lsb_q, stall;
  always_comb begin
    cnt_d  = cnt_q + 3'd1;
    a_d    = addr_q + ADDR_W'(cnt_d);
    byte_d = 8'(data_q >> {cnt_d, 3'b000});
    stall  = wr_q && io_buffer_full && a_q[17:16] == IO_BASE_ADDR[17:16];
  end
  assign mem_a           = a_q;
  assign mem_dout        = dout_q;
  assign mem_wr          = wr_q && !stall;
  assign valid_to_lsb    = state_q == DONE && rdy && lsb_q;
  assign valid_to_icache = state_q == DONE && rdy && !lsb_q;
  assign data_to_lsb     = buf_q;
  assign data_to_icache  = buf_q;
  // A read byte appears on mem_din one cycle after its address, so capture lags the counter by one
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      n_q     <= '0;
      addr_q  <= '0;
      a_q     <= '0;
      data_q  <= '0;
      buf_q   <= '0;
      dout_q  <= '0;
      wr_q    <= 1'b0;
      lsb_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (rdy && (valid_from_lsb || valid_from_icache)) begin
          lsb_q   <= valid_from_lsb;
          addr_q  <= valid_from_lsb ? addr_from_lsb : addr_from_icache;
          a_q     <= valid_from_lsb ? addr_from_lsb : addr_from_icache;
          n_q     <= valid_from_lsb ? size_bytes(size_from_lsb) : 3'd4;
          data_q  <= data_from_lsb;
          dout_q  <= data_from_lsb[7:0];
          buf_q   <= '0;
          cnt_q   <= '0;
          wr_q    <= valid_from_lsb && wr_from_lsb;
          state_q <= valid_from_lsb && wr_from_lsb ? WRITE : READ;
        end
        READ: begin
          if (cnt_q != 3'd0) buf_q <= buf_q | (DATA_W'(mem_din) << {cnt_q - 3'd1, 3'b000});
          if (cnt_q == n_q) state_q <= DONE;
          else begin
            cnt_q <= cnt_d;
            if (cnt_d != n_q) a_q <= a_d;
          end
        end
        WRITE: if (!stall) begin
          if (cnt_d == n_q) begin
            state_q <= DONE;
            wr_q    <= 1'b0;
          end else begin
            cnt_q  <= cnt_d;
            a_q    <= a_d;
            dout_q <= byte_d;
          end
        end
        DONE: if (rdy) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule
